// File: rtl/lmem_seq_pkg.sv
// Shared definitions for the layered-memory read/write-back sequencer.
// Holds the FSM state encoding, code geometry constants and parameter defaults.
// Build option: LMEM_SEQ_EARLY_STOP_EN enables parity-based early termination.
package lmem_seq_pkg;

  // Code geometry: circulant size, block columns, weight per block
  localparam int P          = 26;
  localparam int Nb         = 16;
  localparam int Wt         = 2;
  localparam int CODE_BITS  = 511;

  // One read per circulant-sized slice of the codeword, rounded up
  localparam int NCYC_DEF         = (CODE_BITS + P - 1) / P;
  localparam int LAT_DEF          = 6;
  localparam int ADDRESSWIDTH_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/lmem_seq_ctrl_delay.sv
// Fixed-depth 1-bit delay line turning read strobes into write-back strobes.
// Latency: exactly LAT cycles from i_din to o_dout; no backpressure.
// o_empty is high when no strobe is in flight; i_clr empties it synchronously.
module lmem_seq_delay #(
  parameter int LAT = 6
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_din,
  output logic o_dout,
  output logic o_empty
);

  logic [LAT-1:0] r_sr;

  // Shift strobes toward the output stage; clear drops anything in flight
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_din;
      for (int i = 1; i < LAT; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_dout  = r_sr[LAT-1];
  assign o_empty = ~|r_sr;

endmodule

// File: rtl/lmem_seq_ctrl.sv
// Iterative decoder memory sequencer: per pass, NCYC reads then LAT-delayed write-backs.
// Latency: first read the cycle after start; each write-back LAT cycles after its read.
// No backpressure; start is only honoured in IDLE. Option: LMEM_SEQ_EARLY_STOP_EN.
module lmem_seq_ctrl
  import lmem_seq_pkg::*;
#(
  parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF,
  parameter int NCYC         = NCYC_DEF,
  parameter int LAT          = LAT_DEF,
  parameter int ITERWIDTH    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_regin,
  input  logic [ITERWIDTH-1:0]    iter_limit_regin,
  input  logic                    early_stop_regin,
  output logic                    rd_en_regout,
  output logic [ADDRESSWIDTH-1:0] rd_address_regout,
  output logic                    wr_en_regout,
  output logic                    feedback_en_regout,
  output logic                    busy_regout,
  output logic                    done_regout,
  output logic [ITERWIDTH-1:0]    iter_count_regout
);

`ifdef LMEM_SEQ_EARLY_STOP_EN
  localparam logic EARLY_EN = 1'b1;
`else
  localparam logic EARLY_EN = 1'b0;
`endif

  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(NCYC - 1);
  localparam logic [ITERWIDTH-1:0]    ITER_MAX  = '1;

  state_t               r_state;
  logic [ITERWIDTH-1:0] r_limit;

  logic                 w_dl_empty;
  logic [ITERWIDTH-1:0] w_iter_next;
  logic                 w_stop;

  // Write-back strobe is the read strobe replayed LAT cycles later
  lmem_seq_delay #(
    .LAT (LAT)
  ) u_delay (
    .clk     (clk),
    .i_clr   (rst),
    .i_din   (rd_en_regout),
    .o_dout  (wr_en_regout),
    .o_empty (w_dl_empty)
  );

  // Saturating pass count; a zero limit is promoted to 1 so the limit is always hit first
  assign w_iter_next = (iter_count_regout == ITER_MAX) ? iter_count_regout
                                                        : iter_count_regout + ITERWIDTH'(1);
  assign w_stop      = (w_iter_next == r_limit) | (EARLY_EN & early_stop_regin);

  // Pass sequencer: READ issues addresses, DRAIN waits out in-flight write-backs, CHECK decides
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_limit            <= '0;
      rd_en_regout       <= 1'b0;
      rd_address_regout  <= '0;
      feedback_en_regout <= 1'b0;
      busy_regout        <= 1'b0;
      done_regout        <= 1'b0;
      iter_count_regout  <= '0;
    end else begin
      done_regout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_regin) begin
            r_state            <= ST_READ;
            r_limit            <= (iter_limit_regin == '0) ? ITERWIDTH'(1) : iter_limit_regin;
            rd_en_regout       <= 1'b1;
            rd_address_regout  <= '0;
            feedback_en_regout <= 1'b0;
            busy_regout        <= 1'b1;
            iter_count_regout  <= '0;
          end
        end
        ST_READ: begin
          if (rd_address_regout == LAST_ADDR) begin
            r_state           <= ST_DRAIN;
            rd_en_regout      <= 1'b0;
            rd_address_regout <= '0;
          end else begin
            rd_address_regout <= rd_address_regout + ADDRESSWIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (w_dl_empty) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          iter_count_regout <= w_iter_next;
          if (w_stop) begin
            r_state     <= ST_DONE;
            done_regout <= 1'b1;
          end else begin
            r_state            <= ST_READ;
            rd_en_regout       <= 1'b1;
            rd_address_regout  <= '0;
            feedback_en_regout <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          busy_regout <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          rd_en_regout <= 1'b0;
          busy_regout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmem_seq_ctrl.sv
// Self-checking bench for lmem_seq_ctrl: scoreboard of expected read addresses/feedback,
// read-to-write-back latency tracking, and per-scenario completion checks.
// Build option: LMEM_SEQ_EARLY_STOP_EN selects the early-stop expectation.
module tb_lmem_seq_ctrl;

  localparam int AW = 5;
  localparam int NC = 20;
  localparam int LT = 6;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] iter_limit = '0;
  logic          early_stop = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          fb_en;
  logic          busy;
  logic          done;
  logic [IW-1:0] iter_cnt;

  always #5 clk = ~clk;

  lmem_seq_ctrl #(
    .ADDRESSWIDTH (AW),
    .NCYC         (NC),
    .LAT          (LT),
    .ITERWIDTH    (IW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_regin        (start),
    .iter_limit_regin   (iter_limit),
    .early_stop_regin   (early_stop),
    .rd_en_regout       (rd_en),
    .rd_address_regout  (rd_addr),
    .wr_en_regout       (wr_en),
    .feedback_en_regout (fb_en),
    .busy_regout        (busy),
    .done_regout        (done),
    .iter_count_regout  (iter_cnt)
  );

  typedef struct {
    int addr;
    bit fb;
  } exp_t;

  exp_t exp_q[$];
  int   rd_t_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: reads against expected sequence, write-backs against read times
  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (mon_en && !rst) begin
      if (rd_en) begin
        rd_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected addr=%0d fb=%0d cyc=%0d", rd_addr, fb_en, cyc);
        end else begin
          e = exp_q.pop_front();
          if (rd_addr !== e.addr[AW-1:0] || fb_en !== e.fb) begin
            errors++;
            $display("FAIL rd_seq got addr=%0d fb=%0d expected addr=%0d fb=%0d cyc=%0d",
                     rd_addr, fb_en, e.addr, e.fb, cyc);
          end
        end
        if (rd_addr == '0) begin
          checks++;
          if (rd_t_q.size() != 0) begin
            errors++;
            $display("FAIL rd_before_writeback pending=%0d expected 0 cyc=%0d", rd_t_q.size(), cyc);
          end
        end
        rd_t_q.push_back(cyc);
      end
      if (wr_en) begin
        wr_cnt++;
        checks++;
        if (rd_t_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected cyc=%0d", cyc);
        end else begin
          t = rd_t_q.pop_front();
          if (cyc - t != LT) begin
            errors++;
            $display("FAIL wr_latency got %0d expected %0d", cyc - t, LT);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rd_t_q.delete();
    rd_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic push_passes(int n);
    exp_t e;
    for (int p = 0; p < n; p++) begin
      for (int a = 0; a < NC; a++) begin
        e.addr = a;
        e.fb   = (p > 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(int lim);
    iter_limit = IW'(lim);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({rd_en, rd_addr, wr_en, fb_en, busy, done, iter_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%0d addr=%0d wr=%0d fb=%0d busy=%0d done=%0d iter=%0d expected all 0",
               rd_en, rd_addr, wr_en, fb_en, busy, done, iter_cnt);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rd_en, busy, wr_en} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_start got rd=%0d busy=%0d wr=%0d expected 0", rd_en, busy, wr_en);
    end
  endtask

  task automatic test_three_pass();
    bit ok;
    clear_sb();
    push_passes(3);
    mon_en = 1'b1;
    pulse_start(3);
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== '0) begin
      errors++;
      $display("FAIL first_read got busy=%0d rd=%0d addr=%0d expected 1 1 0", busy, rd_en, rd_addr);
    end
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL three_pass_timeout got no done expected done"); end
    checks++;
    if (rd_cnt != 3*NC || wr_cnt != 3*NC) begin
      errors++;
      $display("FAIL three_pass_counts got rd=%0d wr=%0d expected %0d", rd_cnt, wr_cnt, 3*NC);
    end
    checks++;
    if (done_cnt != 1 || iter_cnt !== IW'(3) || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL three_pass_end got done=%0d iter=%0d busy=%0d left=%0d expected 1 3 0 0",
               done_cnt, iter_cnt, busy, exp_q.size());
    end
  endtask

  task automatic test_limit_zero();
    bit ok;
    clear_sb();
    push_passes(1);
    pulse_start(0);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL limit_zero_timeout got no done expected done"); end
    checks++;
    if (rd_cnt != NC || wr_cnt != NC || done_cnt != 1 || iter_cnt !== IW'(1)) begin
      errors++;
      $display("FAIL limit_zero got rd=%0d wr=%0d done=%0d iter=%0d expected %0d %0d 1 1",
               rd_cnt, wr_cnt, done_cnt, iter_cnt, NC, NC);
    end
  endtask

  task automatic test_early_stop();
    bit ok;
    int np;
`ifdef LMEM_SEQ_EARLY_STOP_EN
    np = 1;
`else
    np = 10;
`endif
    clear_sb();
    push_passes(np);
    early_stop = 1'b1;
    pulse_start(10);
    wait_done(1000, ok);
    early_stop = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL early_stop_timeout got no done expected done"); end
    checks++;
    if (rd_cnt != np*NC || wr_cnt != np*NC || iter_cnt !== IW'(np) || done_cnt != 1) begin
      errors++;
      $display("FAIL early_stop got rd=%0d wr=%0d iter=%0d done=%0d expected %0d %0d %0d 1",
               rd_cnt, wr_cnt, iter_cnt, done_cnt, np*NC, np*NC, np);
    end
  endtask

  task automatic test_start_in_read();
    bit ok;
    bit found;
    clear_sb();
    push_passes(2);
    pulse_start(2);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_en && rd_addr == AW'(5)) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL start_in_read_reach got no addr 5 expected addr 5"); end
    iter_limit = IW'(7);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL start_in_read_timeout got no done expected done"); end
    checks++;
    if (rd_cnt != 2*NC || iter_cnt !== IW'(2) || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_in_read got rd=%0d iter=%0d done=%0d left=%0d expected %0d 2 1 0",
               rd_cnt, iter_cnt, done_cnt, exp_q.size(), 2*NC);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit ok;
    bit found;
    int wr_seen;
    clear_sb();
    push_passes(3);
    pulse_start(3);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_en && fb_en && rd_addr == AW'(7)) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach got no pass2 addr 7 expected it"); end
    rst    = 1'b1;
    mon_en = 1'b0;
    tick();
    checks++;
    if ({rd_en, rd_addr, wr_en, fb_en, busy, done, iter_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got rd=%0d addr=%0d wr=%0d fb=%0d busy=%0d done=%0d iter=%0d expected all 0",
               rd_en, rd_addr, wr_en, fb_en, busy, done, iter_cnt);
    end
    tick();
    rst = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_en !== 1'b0) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      errors++;
      $display("FAIL stale_wr got %0d write strobes expected 0", wr_seen);
    end
    clear_sb();
    push_passes(1);
    mon_en = 1'b1;
    pulse_start(1);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== '0 || fb_en !== 1'b0) begin
      errors++;
      $display("FAIL restart_first got rd=%0d addr=%0d fb=%0d expected 1 0 0", rd_en, rd_addr, fb_en);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || rd_cnt != NC || wr_cnt != NC || iter_cnt !== IW'(1)) begin
      errors++;
      $display("FAIL restart_run got ok=%0d rd=%0d wr=%0d iter=%0d expected 1 %0d %0d 1",
               ok, rd_cnt, wr_cnt, iter_cnt, NC, NC);
    end
  endtask

  initial begin
    test_reset();
    test_three_pass();
    test_limit_zero();
    test_early_stop();
    test_start_in_read();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
